// File: rtl/prbs5_checker.sv
// Self-synchronising serial checker for the x^5+x^3+1 pattern stream with flywheel, lock/loss FSM and error counters.
// Optional first-error capture is built when PRBS5_CHECKER_ERRLOG_EN is defined.
module prbs5_checker #(
    parameter int unsigned LEN      = 5,
    parameter int unsigned TAP_A    = 2,
    parameter int unsigned TAP_B    = 5,
    parameter int unsigned LOCK_CNT = 8,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
`ifdef PRBS5_CHECKER_ERRLOG_EN
    ,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld
`endif
);

    localparam int unsigned FILL_W = $clog2(LEN + 1);
    localparam int unsigned RUN_W  = 8;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [LEN-1:0]     sh_q, sh_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [RUN_W-1:0]   match_q, match_d;
    logic [RUN_W-1:0]   miss_q, miss_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               pred;
`ifdef PRBS5_CHECKER_ERRLOG_EN
    logic [CNT_W-1:0]   fe_idx_q, fe_idx_d;
    logic               fe_vld_q, fe_vld_d;
`endif

    assign pred = sh_q[TAP_A-1] ^ sh_q[TAP_B-1];

    // Next-state: search fills history from din, locked flywheels on the prediction.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        fill_d      = fill_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
`ifdef PRBS5_CHECKER_ERRLOG_EN
        fe_idx_d    = fe_idx_q;
        fe_vld_d    = fe_vld_q;
`endif
        if (din_valid) begin
            case (state_q)
                SEARCH: begin
                    sh_d = {sh_q[LEN-2:0], din};
                    if (fill_q != FILL_W'(LEN)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else if ((din == pred) && (sh_q != '0)) begin
                        if (match_q == RUN_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                        end else begin
                            match_d = match_q + RUN_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    sh_d = {sh_q[LEN-2:0], pred};
                    if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (din != pred) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
`ifdef PRBS5_CHECKER_ERRLOG_EN
                        if (!fe_vld_q) begin
                            fe_idx_d = bit_cnt_q;
                            fe_vld_d = 1'b1;
                        end
`endif
                        if (miss_q == RUN_W'(LOSS_CNT - 1)) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + RUN_W'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        // Clear beats any same-cycle increment and leaves lock state alone.
        if (clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
`ifdef PRBS5_CHECKER_ERRLOG_EN
            fe_idx_d  = '0;
            fe_vld_d  = 1'b0;
`endif
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            sh_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
`ifdef PRBS5_CHECKER_ERRLOG_EN
            fe_idx_q    <= '0;
            fe_vld_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
`ifdef PRBS5_CHECKER_ERRLOG_EN
            fe_idx_q    <= fe_idx_d;
            fe_vld_q    <= fe_vld_d;
`endif
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
    assign bit_count = bit_cnt_q;
`ifdef PRBS5_CHECKER_ERRLOG_EN
    assign first_err_idx = fe_idx_q;
    assign first_err_vld = fe_vld_q;
`endif

endmodule

// File: tb/tb_prbs5_checker.sv
// Directed bench for prbs5_checker: lock, single/burst errors, stuck-0, valid gaps, clear and async reset.
`timescale 1ns/1ps
module tb_prbs5_checker;

    localparam int unsigned CNT_W = 16;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             clear = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
`ifdef PRBS5_CHECKER_ERRLOG_EN
    logic [CNT_W-1:0] first_err_idx;
    logic             first_err_vld;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [4:0] gen_h = 5'b00001;

    always #5 clock = ~clock;

    prbs5_checker dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .din           (din),
        .din_valid     (din_valid),
        .clear         (clear),
        .locked        (locked),
        .err_pulse     (err_pulse),
        .err_count     (err_count),
        .bit_count     (bit_count)
`ifdef PRBS5_CHECKER_ERRLOG_EN
        ,
        .first_err_idx (first_err_idx),
        .first_err_vld (first_err_vld)
`endif
    );

    // Reference generator: b[n] = b[n-2] ^ b[n-5], gen_h[0] newest.
    task automatic gen_bit(output logic b);
        b = gen_h[1] ^ gen_h[4];
        gen_h = {gen_h[3:0], b};
    endtask

    // One clock: drive on falling edge, return 1ns after the sampling edge.
    task automatic send(input logic b, input logic v);
        @(negedge clock);
        din = b;
        din_valid = v;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        rst_n = 1'b0;
        din_valid = 1'b0;
        clear = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic lock_up();
        logic b;
        for (int i = 0; i < 13; i++) begin
            gen_bit(b);
            send(b, 1'b1);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({locked, err_pulse, err_count, bit_count} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got locked=%0b pulse=%0b err=%0d bits=%0d, want all 0",
                     locked, err_pulse, err_count, bit_count);
        end
`ifdef PRBS5_CHECKER_ERRLOG_EN
        n_vec++;
        if ({first_err_vld, first_err_idx} !== '0) begin
            n_err++;
            $display("FAIL reset_errlog: got vld=%0b idx=%0d, want 0/0", first_err_vld, first_err_idx);
        end
`endif
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_lock();
        logic b;
        int lock_at = 0;
        int pulses = 0;
        apply_reset();
        for (int i = 1; i <= 62; i++) begin
            gen_bit(b);
            send(b, 1'b1);
            if (locked === 1'b1 && lock_at == 0) lock_at = i;
            if (err_pulse === 1'b1) pulses++;
        end
        n_vec++;
        if (lock_at !== 13) begin
            n_err++;
            $display("FAIL clean_lock_bit: locked first at valid bit %0d, want 13", lock_at);
        end
        n_vec++;
        if (err_count !== 16'd0 || pulses !== 0) begin
            n_err++;
            $display("FAIL clean_errors: err_count=%0d pulses=%0d, want 0/0", err_count, pulses);
        end
        n_vec++;
        if (bit_count !== 16'd49) begin
            n_err++;
            $display("FAIL clean_bit_count: got %0d, want 49", bit_count);
        end
    endtask

    task automatic test_single_error();
        logic b;
        int pulses = 0;
        int pulse_at = -1;
        int dropped = 0;
        apply_reset();
        lock_up();
        for (int k = 0; k < 40; k++) begin
            gen_bit(b);
            send((k == 20) ? ~b : b, 1'b1);
            if (err_pulse === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
            if (locked !== 1'b1) dropped++;
        end
        n_vec++;
        if (pulses !== 1 || pulse_at !== 20) begin
            n_err++;
            $display("FAIL single_pulse: %0d pulses, last at idx %0d, want 1 at 20", pulses, pulse_at);
        end
        n_vec++;
        if (err_count !== 16'd1 || bit_count !== 16'd40) begin
            n_err++;
            $display("FAIL single_counts: err=%0d bits=%0d, want 1/40", err_count, bit_count);
        end
        n_vec++;
        if (dropped !== 0) begin
            n_err++;
            $display("FAIL single_lock_held: locked low on %0d bits, want 0", dropped);
        end
`ifdef PRBS5_CHECKER_ERRLOG_EN
        n_vec++;
        if (first_err_vld !== 1'b1 || first_err_idx !== 16'd20) begin
            n_err++;
            $display("FAIL single_errlog: vld=%0b idx=%0d, want 1/20", first_err_vld, first_err_idx);
        end
`endif
    endtask

    task automatic test_burst_loss();
        logic b;
        int early = 0;
        apply_reset();
        lock_up();
        for (int k = 0; k < 5; k++) begin
            gen_bit(b);
            send(b, 1'b1);
        end
        for (int j = 0; j < 4; j++) begin
            gen_bit(b);
            send(~b, 1'b1);
            n_vec++;
            if (err_pulse !== 1'b1 || locked !== (j < 3)) begin
                n_err++;
                $display("FAIL burst_bit%0d: pulse=%0b locked=%0b, want 1/%0b", j, err_pulse, locked, j < 3);
            end
        end
        n_vec++;
        if (err_count !== 16'd4 || bit_count !== 16'd9) begin
            n_err++;
            $display("FAIL burst_counts: err=%0d bits=%0d, want 4/9", err_count, bit_count);
        end
        for (int k = 0; k < 12; k++) begin
            gen_bit(b);
            send(b, 1'b1);
            if (locked !== 1'b0) early++;
        end
        gen_bit(b);
        send(b, 1'b1);
        n_vec++;
        if (early !== 0 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL burst_relock: early=%0d locked=%0b after 13 bits, want 0/1", early, locked);
        end
        n_vec++;
        if (err_count !== 16'd4) begin
            n_err++;
            $display("FAIL burst_err_kept: got %0d, want 4", err_count);
        end
`ifdef PRBS5_CHECKER_ERRLOG_EN
        n_vec++;
        if (first_err_vld !== 1'b1 || first_err_idx !== 16'd5) begin
            n_err++;
            $display("FAIL burst_errlog: vld=%0b idx=%0d, want 1/5", first_err_vld, first_err_idx);
        end
`endif
    endtask

    task automatic test_stuck_zero();
        int seen_lock = 0;
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            send(1'b0, 1'b1);
            if (locked !== 1'b0) seen_lock++;
        end
        n_vec++;
        if (seen_lock !== 0 || err_count !== 16'd0 || bit_count !== 16'd0) begin
            n_err++;
            $display("FAIL stuck_zero: lock_cycles=%0d err=%0d bits=%0d, want 0/0/0",
                     seen_lock, err_count, bit_count);
        end
    endtask

    task automatic test_valid_gaps();
        logic b;
        int lock_at = 0;
        int pulses = 0;
        apply_reset();
        for (int i = 1; i <= 62; i++) begin
            gen_bit(b);
            send(b, 1'b1);
            if (locked === 1'b1 && lock_at == 0) lock_at = i;
            if (err_pulse === 1'b1) pulses++;
            for (int g = 0; g < 2; g++) begin
                send(1'($urandom), 1'b0);
                if (err_pulse === 1'b1) pulses++;
            end
        end
        n_vec++;
        if (lock_at !== 13) begin
            n_err++;
            $display("FAIL gaps_lock_bit: locked first at valid bit %0d, want 13", lock_at);
        end
        n_vec++;
        if (pulses !== 0 || err_count !== 16'd0 || bit_count !== 16'd49) begin
            n_err++;
            $display("FAIL gaps_counts: pulses=%0d err=%0d bits=%0d, want 0/0/49",
                     pulses, err_count, bit_count);
        end
    endtask

    task automatic test_clear_reset();
        logic b;
        apply_reset();
        lock_up();
        for (int k = 0; k < 10; k++) begin
            gen_bit(b);
            send((k == 3) ? ~b : b, 1'b1);
        end
        n_vec++;
        if (err_count !== 16'd1 || bit_count !== 16'd10) begin
            n_err++;
            $display("FAIL preclear_counts: err=%0d bits=%0d, want 1/10", err_count, bit_count);
        end
        clear = 1'b1;
        gen_bit(b);
        send(b, 1'b1);
        clear = 1'b0;
        n_vec++;
        if (err_count !== 16'd0 || bit_count !== 16'd0 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL clear: err=%0d bits=%0d locked=%0b, want 0/0/1", err_count, bit_count, locked);
        end
`ifdef PRBS5_CHECKER_ERRLOG_EN
        n_vec++;
        if (first_err_vld !== 1'b0 || first_err_idx !== 16'd0) begin
            n_err++;
            $display("FAIL clear_errlog: vld=%0b idx=%0d, want 0/0", first_err_vld, first_err_idx);
        end
`endif
        for (int k = 0; k < 4; k++) begin
            gen_bit(b);
            send((k == 3) ? ~b : b, 1'b1);
        end
        n_vec++;
        if (bit_count !== 16'd4 || err_count !== 16'd1 || err_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL postclear: bits=%0d err=%0d pulse=%0b, want 4/1/1", bit_count, err_count, err_pulse);
        end
`ifdef PRBS5_CHECKER_ERRLOG_EN
        n_vec++;
        if (first_err_vld !== 1'b1 || first_err_idx !== 16'd3) begin
            n_err++;
            $display("FAIL postclear_errlog: vld=%0b idx=%0d, want 1/3", first_err_vld, first_err_idx);
        end
`endif
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({locked, err_pulse, err_count, bit_count} !== '0) begin
            n_err++;
            $display("FAIL async_reset: locked=%0b pulse=%0b err=%0d bits=%0d, want all 0",
                     locked, err_pulse, err_count, bit_count);
        end
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_burst_loss();
        test_stuck_zero();
        test_valid_gaps();
        test_clear_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
